// File: rtl/conv_window_gen_pkg.sv
// Shared convolution-layer definitions: default geometry and the window
// element indexing helper, so producers and consumers unpack win_data alike.
package conv_window_gen_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;

  // Bit offset of window element (r,c) inside the packed window bus.
  function automatic int win_idx(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

  // Counter width for a dimension of n positions (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage, addressed by the column counter.
// The read is combinational from the current contents, so a write in the
// same cycle lands after the old value has been picked up (read-before-write).
module conv_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int AW     = cnt_w(DEF_IMG_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  // Row storage write; contents are never reset, stale data is masked upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding K x K window generator over a raster pixel stream with
// valid/ready flow control, frame tracking and synchronous clear.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic                    frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

  logic              acc;
  logic              col_end;
  logic              row_end;
  logic              win_pos;
  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [DATA_W-1:0] lb_rd  [K-1];
  logic [DATA_W-1:0] lb_wr  [K-1];
  logic [DATA_W-1:0] col_vec [K];
  logic [DATA_W-1:0] win_p1 [K][K];
  logic              vld_p1;
  logic              done_p1;

  // A new pixel may enter only when the current window slot is free or
  // being drained this cycle; clear blocks acceptance outright.
  assign in_ready   = !clr && (!vld_p1 || out_ready);
  assign acc        = in_valid && in_ready;
  assign col_end    = (col_p0 == COL_LAST);
  assign row_end    = (row_p0 == ROW_LAST);
  assign win_pos    = (row_p0 >= ROW_WIN0) && (col_p0 >= COL_WIN0);
  assign out_valid  = vld_p1;
  assign frame_done = done_p1;

  // ---- stage p0: column vector from line buffers plus the incoming pixel ----
  assign col_vec[K-1] = in_data;

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    assign col_vec[j] = lb_rd[j];
    // Each stored row moves one slot toward the oldest; the newest takes in_data.
    assign lb_wr[j]   = col_vec[j+1];

    conv_line_buffer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .AW     (CW)
    ) u_lb (
      .clk     (clk),
      .wr_en   (acc),
      .addr    (col_p0),
      .wr_data (lb_wr[j]),
      .rd_data (lb_rd[j])
    );
  end

  // Raster position tracking; wraps at end of row and end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (clr) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (acc) begin
      if (col_end) begin
        col_p0 <= '0;
        row_p0 <= row_end ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: window shift register, valid and frame-end pulse ----
  // Window shifts left by one column per accepted pixel, new column enters on the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_p1[r][c] <= '0;
        end
      end
    end else if (acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_p1[r][c] <= win_p1[r][c+1];
        end
        win_p1[r][K-1] <= col_vec[r];
      end
    end
  end

  // Window valid: loaded on every accept, dropped once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
    end else if (acc) begin
      vld_p1 <= win_pos;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Single-cycle pulse following acceptance of the frame's final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_p1 <= 1'b0;
    end else if (clr) begin
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= acc && row_end && col_end;
    end
  end

  // Flatten the window array onto the output bus, row 0 / column 0 lowest.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_data[win_idx(r, c, K, DATA_W) +: DATA_W] = win_p1[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen with a 5x4 image and 3x3 kernel.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int KK = 3;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int WB = KK * KK * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WB-1:0] win_data;
  logic          frame_done;

  int checks = 0;
  int fails  = 0;
  int pops   = 0;
  int fd_seen = 0;

  logic [WB-1:0] exp_win[$];
  bit            exp_fd[$];

  // Top-left pixel value of each of the six windows in raster order.
  int tl_tab [6] = '{0, 1, 2, 5, 6, 7};

  conv_window_gen #(
    .DATA_W (DW),
    .K      (KK),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .win_data   (win_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk_w(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] mk_win(input int tl);
    logic [WB-1:0] w;
    w = '0;
    for (int rr = 0; rr < KK; rr++) begin
      for (int cc = 0; cc < KK; cc++) begin
        w[(rr*KK+cc)*DW +: DW] = DW'(tl + rr * IW + cc);
      end
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pixel; returns 1 ns after the accepting edge.
  task automatic send_pixel(input int r, input int c);
    int  waited;
    bit  done;
    bit  got;
    bit  qual;
    waited = 0;
    done   = 0;
    got    = 0;
    in_valid = 1'b1;
    in_data  = DW'(r * IW + c);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
        got  = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          fails++;
          $display("FAIL accept_timeout pixel=%0d actual=not_accepted required=accepted", r * IW + c);
          done = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
    if (got) begin
      qual = (r >= KK - 1) && (c >= KK - 1);
      if (qual) begin
        exp_win.push_back(mk_win(tl_tab[(r - (KK - 1)) * (IW - KK + 1) + (c - (KK - 1))]));
        exp_fd.push_back((r == IH - 1) && (c == IW - 1));
      end
      chk_b("lat_out_valid", out_valid, qual);
      chk_b("lat_frame_done", frame_done, (r == IH - 1) && (c == IW - 1));
    end
  endtask

  task automatic stream(input int first, input int last, input bit gaps);
    int p;
    for (int i = first; i <= last; i++) begin
      p = i % (IW * IH);
      if (gaps) idle($urandom_range(0, 1));
      send_pixel(p / IW, p % IW);
    end
  endtask

  // Monitor: every handshake pops one expected window from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_seen++;
      if (out_valid && out_ready) begin
        if (exp_win.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_window actual=%h required=none", win_data);
        end else begin
          logic [WB-1:0] w;
          bit f;
          w = exp_win.pop_front();
          f = exp_fd.pop_front();
          chk_w("window", win_data, w);
          chk_b("window_frame_done", frame_done, f);
          pops++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int f0;
    logic [WB-1:0] held;

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_win_data", win_data, '0);
    chk_b("rst_frame_done", frame_done, 1'b0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Full frame, consumer always ready.
    p0 = pops;
    stream(0, 19, 0);
    idle(3);
    chk_i("s1_windows", pops - p0, 6);
    chk_i("s1_queue_empty", exp_win.size(), 0);

    // Backpressure on the second window for ten cycles.
    p0 = pops;
    stream(0, 13, 0);
    out_ready = 1'b0;
    held = win_data;
    chk_w("s2_held_value", held, mk_win(1));
    repeat (10) begin
      @(negedge clk);
      chk_b("s2_in_ready_low", in_ready, 1'b0);
      chk_b("s2_out_valid_hold", out_valid, 1'b1);
      chk_w("s2_win_stable", win_data, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    stream(14, 19, 0);
    idle(3);
    chk_i("s2_windows", pops - p0, 6);

    // Random input gaps.
    p0 = pops;
    stream(0, 19, 1);
    idle(3);
    chk_i("s3_windows", pops - p0, 6);

    // Synchronous clear after pixel 13, then a fresh frame.
    p0 = pops;
    stream(0, 13, 0);
    clr = 1'b1;
    #1;
    chk_b("s4_in_ready_clr", in_ready, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_b("s4_out_valid_clr", out_valid, 1'b0);
    chk_b("s4_frame_done_clr", frame_done, 1'b0);
    stream(0, 19, 0);
    idle(3);
    chk_i("s4_windows", pops - p0, 2 + 6);

    // Asynchronous reset mid-frame, then a fresh frame.
    p0 = pops;
    stream(0, 8, 0);
    rst_n = 1'b0;
    #1;
    chk_b("s5_in_ready", in_ready, 1'b1);
    chk_b("s5_out_valid", out_valid, 1'b0);
    chk_w("s5_win_data", win_data, '0);
    chk_b("s5_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stream(0, 19, 0);
    idle(3);
    chk_i("s5_windows", pops - p0, 6);

    // Two frames back to back.
    p0 = pops;
    f0 = fd_seen;
    stream(0, 39, 0);
    idle(3);
    chk_i("s6_windows", pops - p0, 12);
    chk_i("s6_frame_done_pulses", fd_seen - f0, 2);
    chk_i("s6_queue_empty", exp_win.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
